// File: rtl/regfile_bist.sv
// -----------------------------------------------------------------------------
// regfile_bist
//   Built-in self-test initiator for a NUM_REGS x DATA_W register file.
//   It writes every register once, then reads them back on both read ports and
//   compares the returned data with the expected pattern.
//
//   Ports (summary):
//     clock, ctrl_reset         clock and asynchronous active-high reset
//     start, seed               start request (level) and base data pattern
//     ctrl_writeEn/.. data_writeReg   regfile write port (driven)
//     ctrl_readRegA/B           regfile read addresses (driven)
//     data_readRegA/B           regfile read data (observed)
//     busy, done, pass          test status
//     error_count               mismatch count, saturating at all-ones
//     first_fail_addr/_valid    address of the first mismatch
//     state_dbg                 current FSM state encoding, for debug/observation
//
//   start protocol: start is a level, sampled on each rising clock edge. It is
//   accepted only in IDLE or DONE; while the test runs it is ignored. There is
//   no acknowledge: acceptance is visible as busy rising after the edge.
//
//   Every output is decoded from registered state only (state, idx, seed and
//   the result registers), so outputs never change between clock edges except
//   when reset is asserted.
// -----------------------------------------------------------------------------
module regfile_bist #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter bit R0_ZERO  = 1'b0
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              ctrl_writeEn,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [ADDR_W-1:0] ctrl_readRegA,
  output logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic [DATA_W-1:0] data_readRegB,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] error_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              first_fail_valid,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ADDR_W+1:0] err_q, err_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic              ffv_q, ffv_d;

  // Port B walks the register file from the top while port A walks from the
  // bottom, so both ports see every address once over the read sweep.
  logic [ADDR_W-1:0] addr_b;
  assign addr_b = LAST_IDX - idx_q;

  // Expected read-back value. Register 0 may be a hardwired zero in the
  // target regfile, in which case its expected value is 0 even though the
  // write sweep still writes the raw pattern to it.
  function automatic logic [DATA_W-1:0] exp_val(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    if (R0_ZERO && (a == '0)) return '0;
    return s ^ DATA_W'(a);
  endfunction

  logic              mis_a, mis_b;
  logic [1:0]        mis_cnt;
  logic [ADDR_W+2:0] err_sum;
  logic [ADDR_W+1:0] err_sat;

  always_comb begin
    mis_a   = (data_readRegA != exp_val(seed_q, idx_q));
    mis_b   = (data_readRegB != exp_val(seed_q, addr_b));
    mis_cnt = {1'b0, mis_a} + {1'b0, mis_b};
    // One extra bit catches overflow so the counter sticks at all-ones.
    err_sum = {1'b0, err_q} + (ADDR_W+3)'(mis_cnt);
    err_sat = err_sum[ADDR_W+2] ? '1 : err_sum[ADDR_W+1:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seed_d  = seed_q;
    err_d   = err_q;
    ffa_d   = ffa_q;
    ffv_d   = ffv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          seed_d  = seed;
          err_d   = '0;
          ffa_d   = '0;
          ffv_d   = 1'b0;
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_READ;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        err_d = err_sat;
        // Only the first mismatch is kept; port A takes priority on a tie.
        if (!ffv_q && (mis_a || mis_b)) begin
          ffv_d = 1'b1;
          ffa_d = mis_a ? idx_q : addr_b;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ffa_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      ffv_q   <= ffv_d;
    end
  end

  // Moore output decode
  always_comb begin
    ctrl_writeEn     = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    busy             = 1'b0;
    done             = 1'b0;
    pass             = 1'b0;
    error_count      = err_q;
    first_fail_addr  = ffa_q;
    first_fail_valid = ffv_q;
    state_dbg        = state_q;
    case (state_q)
      S_WRITE: begin
        busy          = 1'b1;
        ctrl_writeEn  = 1'b1;
        ctrl_writeReg = idx_q;
        data_writeReg = seed_q ^ DATA_W'(idx_q);
      end
      S_READ, S_CHECK: begin
        busy          = 1'b1;
        ctrl_readRegA = idx_q;
        ctrl_readRegB = addr_b;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (err_q == '0);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_bist.sv
// -----------------------------------------------------------------------------
// tb_regfile_bist
//   Bench for regfile_bist. Two instances run side by side on the same
//   stimulus, one with R0_ZERO=0 and one with R0_ZERO=1, each attached to its
//   own behavioural register file that can carry an injected fault.
//   Expected results come from a reference model that computes the final
//   register contents from the write sweep and the fault, then walks the
//   read sweep comparing against the expected pattern.
// -----------------------------------------------------------------------------
module tb_regfile_bist;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] seed;

  // instance 0: R0_ZERO=0, instance 1: R0_ZERO=1
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [4:0]  ra0, ra1, rb0, rb1;
  logic [31:0] rda0, rda1, rdb0, rdb1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [6:0]  err0, err1;
  logic [4:0]  ffa0, ffa1;
  logic        ffv0, ffv1;
  logic [2:0]  st0, st1;

  regfile_bist #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .R0_ZERO(1'b0)) dut0 (
    .clock(clk), .ctrl_reset(rst), .start(start), .seed(seed),
    .ctrl_writeEn(we0), .ctrl_writeReg(wa0), .data_writeReg(wd0),
    .ctrl_readRegA(ra0), .ctrl_readRegB(rb0),
    .data_readRegA(rda0), .data_readRegB(rdb0),
    .busy(busy0), .done(done0), .pass(pass0), .error_count(err0),
    .first_fail_addr(ffa0), .first_fail_valid(ffv0), .state_dbg(st0)
  );

  regfile_bist #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .R0_ZERO(1'b1)) dut1 (
    .clock(clk), .ctrl_reset(rst), .start(start), .seed(seed),
    .ctrl_writeEn(we1), .ctrl_writeReg(wa1), .data_writeReg(wd1),
    .ctrl_readRegA(ra1), .ctrl_readRegB(rb1),
    .data_readRegA(rda1), .data_readRegB(rdb1),
    .busy(busy1), .done(done1), .pass(pass1), .error_count(err1),
    .first_fail_addr(ffa1), .first_fail_valid(ffv1), .state_dbg(st1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  // fault modes: 0 ideal, 1 reg7 bit3 stuck-0, 2 reg31 writes land in reg30,
  // 3 reg0 hardwired zero, 4 random stuck bit
  int       fault_mode = 0;
  int       rf_addr    = 0;
  int       rf_bit     = 0;
  bit       rf_val     = 1'b0;
  logic     fill_req   = 1'b0;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  logic [36:0] exp_q [$];
  logic [36:0] wr_q  [$];
  int          busy_cyc;
  bit          timed_out;
  logic        snap_busy;
  logic [14:0] snap_res;

  logic [14:0] res0, res1;
  assign res0 = {done0, pass0, ffv0, ffa0, err0};
  assign res1 = {done1, pass1, ffv1, ffa1, err1};

  // ---------------- behavioural register file ----------------
  function automatic logic [4:0] wmap(input logic [4:0] a, input int fm);
    if (fm == 2 && a == 5'd31) return 5'd30;
    return a;
  endfunction

  function automatic logic [31:0] apply_fault(input logic [31:0] v, input logic [4:0] a,
                                              input int fm, input int fa, input int fb,
                                              input bit fv);
    logic [31:0] r;
    r = v;
    if (fm == 1 && a == 5'd7) r[3] = 1'b0;
    if (fm == 3 && a == 5'd0) r = '0;
    if (fm == 4 && int'(a) == fa) r[fb] = fv;
    return r;
  endfunction

  assign rda0 = apply_fault(mem0[ra0], ra0, fault_mode, rf_addr, rf_bit, rf_val);
  assign rdb0 = apply_fault(mem0[rb0], rb0, fault_mode, rf_addr, rf_bit, rf_val);
  assign rda1 = apply_fault(mem1[ra1], ra1, fault_mode, rf_addr, rf_bit, rf_val);
  assign rdb1 = apply_fault(mem1[rb1], rb1, fault_mode, rf_addr, rf_bit, rf_val);

  // fill_req loads random garbage so that only the sweep's writes can
  // produce the expected contents; reg31 starts at 0 for the aliasing fault.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= (fault_mode == 2 && i == 31) ? 32'd0 : $urandom;
        mem1[i] <= (fault_mode == 2 && i == 31) ? 32'd0 : $urandom;
      end
    end else begin
      if (we0) mem0[wmap(wa0, fault_mode)] <= wd0;
      if (we1) mem1[wmap(wa1, fault_mode)] <= wd1;
    end
  end

  // ---------------- reference model ----------------
  // Value a healthy sweep leaves readable at address a, given the fault.
  function automatic logic [31:0] final_val(input logic [31:0] s, input int a);
    logic [31:0] b;
    b = s ^ 32'(a);
    if (fault_mode == 2 && a == 31) b = 32'd0;
    if (fault_mode == 2 && a == 30) b = s ^ 32'd31;
    return apply_fault(b, 5'(a), fault_mode, rf_addr, rf_bit, rf_val);
  endfunction

  function automatic logic [31:0] want_val(input logic [31:0] s, input int a, input bit r0);
    if (r0 && a == 0) return 32'd0;
    return s ^ 32'(a);
  endfunction

  // Packed {done, pass, first_fail_valid, first_fail_addr, error_count}
  function automatic logic [14:0] exp_res(input logic [31:0] s, input bit r0);
    int         errs;
    bit         fv;
    logic [4:0] fa;
    int         addrs [2];
    errs = 0;
    fv   = 1'b0;
    fa   = '0;
    for (int idx = 0; idx < 32; idx++) begin
      addrs[0] = idx;
      addrs[1] = 31 - idx;
      for (int p = 0; p < 2; p++) begin
        if (final_val(s, addrs[p]) != want_val(s, addrs[p], r0)) begin
          errs++;
          if (!fv) begin
            fv = 1'b1;
            fa = 5'(addrs[p]);
          end
        end
      end
    end
    return {1'b1, (errs == 0), fv, fa, 7'(errs)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_mem();
    @(negedge clk) fill_req = 1'b1;
    @(negedge clk) fill_req = 1'b0;
  endtask

  task automatic build_exp(input logic [31:0] s);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), s ^ 32'(i)});
  endtask

  // Starts a run and follows it to DONE (bounded). Records busy cycles,
  // the write stream of instance 0, and a snapshot just after acceptance.
  task automatic run_bist(input logic [31:0] s, input bit pulse_busy);
    fill_mem();
    wr_q.delete();
    busy_cyc  = 0;
    timed_out = 1'b1;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    snap_busy = busy0;
    snap_res  = res0;
    for (int c = 1; c < 400; c++) begin
      if (busy0) busy_cyc++;
      if (we0) wr_q.push_back({wa0, wd0});
      if (done0) begin
        timed_out = 1'b0;
        break;
      end
      if (pulse_busy) begin
        start = (c == 10 || c == 50);
        if (c == 10 || c == 50) seed = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    seed  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, we0, wa0, wd0, ra0, rb0, res0} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_r0z0 got=%h exp=0", {busy0, we0, wa0, wd0, ra0, rb0, res0});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, we1, wa1, wd1, ra1, rb1, res1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_r0z1 got=%h exp=0", {busy1, we1, wa1, wd1, ra1, rb1, res1});
    end
  endtask

  task automatic test_ideal();
    logic [14:0] e0, e1;
    fault_mode = 0;
    run_bist(32'h0000DEAD, 1'b0);
    build_exp(32'h0000DEAD);
    e0 = exp_res(32'h0000DEAD, 1'b0);
    e1 = exp_res(32'h0000DEAD, 1'b1);
    checks++;
    if (timed_out || busy_cyc != 96) begin
      failures++;
      $display("FAIL ideal_busy_cycles got=%0d exp=96 timeout=%0d", busy_cyc, timed_out);
    end
    checks++;
    if (wr_q.size() != 32) begin
      failures++;
      $display("FAIL ideal_write_count got=%0d exp=32", wr_q.size());
    end
    for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ideal_write_%0d got=%h exp=%h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (res0 !== e0) begin
      failures++;
      $display("FAIL ideal_result_r0z0 got=%h exp=%h", res0, e0);
    end
    checks++;
    if (res1 !== e1) begin
      failures++;
      $display("FAIL ideal_result_r0z1 got=%h exp=%h", res1, e1);
    end
  endtask

  task automatic test_fault(input int fm, input logic [31:0] s);
    logic [14:0] e0, e1;
    fault_mode = fm;
    run_bist(s, 1'b0);
    e0 = exp_res(s, 1'b0);
    e1 = exp_res(s, 1'b1);
    checks++;
    if (timed_out || busy_cyc != 96) begin
      failures++;
      $display("FAIL fault%0d_busy_cycles got=%0d exp=96 timeout=%0d", fm, busy_cyc, timed_out);
    end
    checks++;
    if (res0 !== e0) begin
      failures++;
      $display("FAIL fault%0d_result_r0z0 got=%h exp=%h", fm, res0, e0);
    end
    checks++;
    if (res1 !== e1) begin
      failures++;
      $display("FAIL fault%0d_result_r0z1 got=%h exp=%h", fm, res1, e1);
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] e0;
    fault_mode = 0;
    fill_mem();
    @(negedge clk);
    seed  = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy_before got=%0b exp=1", busy0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy0, done0, we0, busy1, done1, we1, err0, ffv0} !== '0) begin
      failures++;
      $display("FAIL reset_mid_immediate got=%h exp=0",
               {busy0, done0, we0, busy1, done1, we1, err0, ffv0});
    end
    @(negedge clk);
    rst = 1'b0;
    run_bist(32'h0000DEAD, 1'b0);
    e0 = exp_res(32'h0000DEAD, 1'b0);
    checks++;
    if (timed_out || busy_cyc != 96 || res0 !== e0) begin
      failures++;
      $display("FAIL reset_mid_rerun got=%h/%0d exp=%h/96", res0, busy_cyc, e0);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] s;
    logic [14:0] e0;
    fault_mode = 0;
    s = $urandom;
    run_bist(s, 1'b1);
    build_exp(s);
    e0 = exp_res(s, 1'b0);
    checks++;
    if (timed_out || busy_cyc != 96) begin
      failures++;
      $display("FAIL busy_start_cycles got=%0d exp=96 timeout=%0d", busy_cyc, timed_out);
    end
    checks++;
    if (wr_q.size() != 32) begin
      failures++;
      $display("FAIL busy_start_write_count got=%0d exp=32", wr_q.size());
    end
    for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_start_write_%0d got=%h exp=%h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (res0 !== e0) begin
      failures++;
      $display("FAIL busy_start_result got=%h exp=%h", res0, e0);
    end
  endtask

  task automatic test_restart_in_done();
    logic [14:0] e0;
    fault_mode = 1;
    run_bist(32'h0000DEAD, 1'b0);
    e0 = exp_res(32'h0000DEAD, 1'b0);
    checks++;
    if (res0 !== e0) begin
      failures++;
      $display("FAIL restart_first_run got=%h exp=%h", res0, e0);
    end
    fault_mode = 0;
    run_bist(32'h12345678, 1'b0);
    checks++;
    if (snap_busy !== 1'b1 || snap_res !== '0) begin
      failures++;
      $display("FAIL restart_cleared got=busy%0b/%h exp=busy1/0", snap_busy, snap_res);
    end
    e0 = exp_res(32'h12345678, 1'b0);
    checks++;
    if (timed_out || res0 !== e0) begin
      failures++;
      $display("FAIL restart_second_run got=%h exp=%h", res0, e0);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    fault_mode = 0;
    fill_mem();
    @(negedge clk);
    seed  = 32'hA5A5_0F0F;
    start = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (!seen || busy0 !== 1'b1 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_restart got=seen%0b busy%0b done%0b exp=seen1 busy1 done0",
               seen, busy0, done0);
    end
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    checks++;
    if (!seen || res0 !== exp_res(32'hA5A5_0F0F, 1'b0)) begin
      failures++;
      $display("FAIL back_to_back_result got=%h exp=%h", res0, exp_res(32'hA5A5_0F0F, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [31:0] s;
    logic [14:0] e0, e1;
    for (int n = 0; n < 6; n++) begin
      fault_mode = $urandom_range(0, 4);
      rf_addr    = $urandom_range(0, 31);
      rf_bit     = $urandom_range(0, 31);
      rf_val     = 1'($urandom_range(0, 1));
      s          = $urandom;
      run_bist(s, 1'b0);
      build_exp(s);
      e0 = exp_res(s, 1'b0);
      e1 = exp_res(s, 1'b1);
      checks++;
      if (timed_out || busy_cyc != 96 || wr_q.size() != 32) begin
        failures++;
        $display("FAIL rand%0d_timing busy=%0d writes=%0d exp=96/32", n, busy_cyc, wr_q.size());
      end
      for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_write_%0d got=%h exp=%h", n, i, wr_q[i], exp_q[i]);
        end
      end
      checks++;
      if (res0 !== e0) begin
        failures++;
        $display("FAIL rand%0d_result_r0z0 mode=%0d got=%h exp=%h", n, fault_mode, res0, e0);
      end
      checks++;
      if (res1 !== e1) begin
        failures++;
        $display("FAIL rand%0d_result_r0z1 mode=%0d got=%h exp=%h", n, fault_mode, res1, e1);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    seed  = '0;
    test_reset();
    test_ideal();
    test_fault(1, 32'h0000DEAD);
    test_fault(2, 32'h0000DEAD);
    test_fault(3, 32'h0000DEAD);
    test_reset_mid();
    test_start_while_busy();
    test_restart_in_done();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
